// File: rtl/ks_serial_adder_pkg.sv
// Shared definitions for the byte-serial Kogge-Stone adder slice.
package ks_pkg;

    localparam int KS_W         = 8;
    localparam int KS_MAX_BYTES = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    // Byte index width; a one-byte operand still needs a one-bit counter.
    function automatic int ks_idx_w(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/ks_serial_adder_if.sv
// Operand/sum handshake bundle between the pin-level bus and the readback logic.
interface ks_serial_adder_if;
    import ks_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [KS_W-1:0] in_a;
    logic [KS_W-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [KS_W-1:0] out_sum;
    logic            out_last;
    logic            out_cout;
    logic            out_ovf;
    logic            out_zero;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_zero
    );

endinterface

// File: rtl/ks_serial_adder_adder8.sv
// Combinational 8-bit Kogge-Stone adder; carry-in is folded into bit 0 generate.
module ks_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] g0, p0, g1, p1, g2, p2, g3;

    // Bit-level generate/propagate with carry-in absorbed into bit 0
    always_comb begin
        p0    = a ^ b;
        g0    = a & b;
        g0[0] = (a[0] & b[0]) | (p0[0] & cin);
    end

    // Prefix level 1: span 2
    always_comb begin
        g1 = g0;
        p1 = p0;
        for (int i = 1; i < 8; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end
    end

    // Prefix level 2: span 4
    always_comb begin
        g2 = g1;
        p2 = p1;
        for (int i = 2; i < 8; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end
    end

    // Prefix level 3: span 8, g3[i] is the carry out of bit i
    always_comb begin
        g3 = g2;
        for (int i = 4; i < 8; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
        end
    end

    // Sum bits from propagate and the carry into each position
    always_comb begin
        sum[0] = p0[0] ^ cin;
        for (int i = 1; i < 8; i++) begin
            sum[i] = p0[i] ^ g3[i-1];
        end
        cout = g3[7];
    end

endmodule

// File: rtl/ks_serial_adder.sv
// Byte-serial NBYTES*8-bit adder: LSB-first operand bytes in, one registered
// sum byte out per beat, with carry/overflow/zero flags on the last byte.
module ks_serial_adder
    import ks_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    ks_serial_adder_if.slave     bus
);
    localparam int                IDX_W    = ks_idx_w(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    ks_state_e       state;
    logic [IDX_W-1:0] idx;
    logic            carry;
    logic            zacc;

    logic            vld_p0;
    logic [KS_W-1:0] sum_p0;
    logic            last_p0, cout_p0, ovf_p0, zero_p0;

    logic            in_acc, is_last, cin;
    logic [KS_W-1:0] s;
    logic            c;

    assign bus.in_ready  = !vld_p0 || bus.out_ready;
    assign in_acc        = bus.in_valid && bus.in_ready;
    assign is_last       = (idx == LAST_IDX);
    // Carry is only live mid-operand; byte 0 always starts from zero.
    assign cin           = (state == ST_RUN) ? carry : 1'b0;

    ks_adder8 u_adder (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .cin  (cin),
        .sum  (s),
        .cout (c)
    );

    // Control, carry chain, zero accumulator and the single output register
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            zacc    <= 1'b1;
            vld_p0  <= 1'b0;
            sum_p0  <= '0;
            last_p0 <= 1'b0;
            cout_p0 <= 1'b0;
            ovf_p0  <= 1'b0;
            zero_p0 <= 1'b0;
        end else if (in_acc) begin
            vld_p0  <= 1'b1;
            sum_p0  <= s;
            last_p0 <= is_last;
            cout_p0 <= is_last && c;
            ovf_p0  <= is_last && (bus.in_a[7] == bus.in_b[7]) && (s[7] != bus.in_a[7]);
            zero_p0 <= is_last && zacc && (s == '0);
            if (is_last) begin
                state <= ST_IDLE;
                idx   <= '0;
                carry <= 1'b0;
                zacc  <= 1'b1;
            end else begin
                state <= ST_RUN;
                idx   <= idx + IDX_W'(1);
                carry <= c;
                zacc  <= zacc && (s == '0);
            end
        end else if (bus.out_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.out_sum   = sum_p0;
    assign bus.out_last  = last_p0;
    assign bus.out_cout  = cout_p0;
    assign bus.out_ovf   = ovf_p0;
    assign bus.out_zero  = zero_p0;

endmodule

// File: tb/tb_ks_serial_adder.sv
// Directed bench for ks_serial_adder: a 4-byte and a 1-byte instance.
module tb_ks_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    ks_serial_adder_if ifc4 ();
    ks_serial_adder_if ifc1 ();

    ks_serial_adder #(.NBYTES(4)) dut4 (.clk(clk), .rst(rst), .clr(clr), .bus(ifc4));
    ks_serial_adder #(.NBYTES(1)) dut1 (.clk(clk), .rst(rst), .clr(clr), .bus(ifc1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle4(input string tag);
        check({tag, "_out4"}, {ifc4.out_valid, ifc4.out_sum, ifc4.out_last,
                              ifc4.out_cout, ifc4.out_ovf, ifc4.out_zero}, 0);
        check({tag, "_rdy4"}, ifc4.in_ready, 1);
    endtask

    task automatic chk_idle1(input string tag);
        check({tag, "_out1"}, {ifc1.out_valid, ifc1.out_sum, ifc1.out_last,
                              ifc1.out_cout, ifc1.out_ovf, ifc1.out_zero}, 0);
        check({tag, "_rdy1"}, ifc1.in_ready, 1);
    endtask

    // Drive one 4-byte byte pair and check the registered result one edge later
    task automatic beat4(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] s, input logic [3:0] flags);
        @(negedge clk);
        ifc4.in_valid  = 1'b1;
        ifc4.in_a      = a;
        ifc4.in_b      = b;
        ifc4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_vld"}, ifc4.out_valid, 1);
        check({tag, "_sum"}, ifc4.out_sum, s);
        check({tag, "_flg"}, {ifc4.out_last, ifc4.out_cout, ifc4.out_ovf, ifc4.out_zero}, flags);
    endtask

    task automatic run4(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s, input logic cout, input logic ovf,
                        input logic zero);
        for (int i = 0; i < 4; i++) begin
            beat4($sformatf("%s_b%0d", tag, i), a[8*i +: 8], b[8*i +: 8], s[8*i +: 8],
                  (i == 3) ? {1'b1, cout, ovf, zero} : 4'b0000);
        end
        @(negedge clk);
        ifc4.in_valid = 1'b0;
    endtask

    task automatic beat1(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] s, input logic [3:0] flags);
        @(negedge clk);
        ifc1.in_valid  = 1'b1;
        ifc1.in_a      = a;
        ifc1.in_b      = b;
        ifc1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_vld"}, ifc1.out_valid, 1);
        check({tag, "_sum"}, ifc1.out_sum, s);
        check({tag, "_flg"}, {ifc1.out_last, ifc1.out_cout, ifc1.out_ovf, ifc1.out_zero}, flags);
    endtask

    initial begin
        ifc4.in_valid = 1'b0; ifc4.in_a = '0; ifc4.in_b = '0; ifc4.out_ready = 1'b1;
        ifc1.in_valid = 1'b0; ifc1.in_a = '0; ifc1.in_b = '0; ifc1.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle4("rst");
        chk_idle1("rst");
        @(negedge clk);
        rst = 1'b0;

        // Basic vectors, back-to-back with out_ready held high
        run4("ff_1",   32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run4("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run4("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run4("mix",    32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        run4("negovf", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1);

        // Backpressure after byte 1 of 0xFF + 0x01
        beat4("bp_b0", 8'hFF, 8'h01, 8'h00, 4'b0000);
        beat4("bp_b1", 8'h00, 8'h00, 8'h01, 4'b0000);
        @(negedge clk);
        ifc4.out_ready = 1'b0;
        ifc4.in_a      = 8'h00;
        ifc4.in_b      = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_rdy%0d", k), ifc4.in_ready, 0);
            check($sformatf("bp_hold%0d", k), {ifc4.out_valid, ifc4.out_sum}, 9'h101);
        end
        beat4("bp_b2", 8'h00, 8'h00, 8'h00, 4'b0000);
        beat4("bp_b3", 8'h00, 8'h00, 8'h00, 4'b1000);
        @(negedge clk);
        ifc4.in_valid = 1'b0;

        // Abort after two bytes of 0xFFFFFFFF + 1, then a fresh 2 + 3
        beat4("clr_b0", 8'hFF, 8'h01, 8'h00, 4'b0000);
        beat4("clr_b1", 8'hFF, 8'h00, 8'h00, 4'b0000);
        @(negedge clk);
        clr          = 1'b1;
        ifc4.in_a    = 8'hFF;
        ifc4.in_b    = 8'h00;
        @(posedge clk);
        #1;
        check("clr_vld", ifc4.out_valid, 0);
        @(negedge clk);
        clr           = 1'b0;
        ifc4.in_valid = 1'b0;
        run4("after_clr", 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an operand
        beat4("rr_b0", 8'hFF, 8'hFF, 8'hFE, 4'b0000);
        beat4("rr_b1", 8'hFF, 8'hFF, 8'hFF, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_idle4("rst_run");
        @(negedge clk);
        rst           = 1'b0;
        ifc4.in_valid = 1'b0;
        run4("after_rst", 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        // One-byte operands: every beat is last, no carry carried between beats
        beat1("n1_a", 8'h80, 8'h80, 8'h00, 4'b1111);
        beat1("n1_b", 8'h80, 8'h80, 8'h00, 4'b1111);
        beat1("n1_c", 8'h01, 8'h02, 8'h03, 4'b1000);
        beat1("n1_d", 8'h7F, 8'h01, 8'h80, 4'b1010);
        @(negedge clk);
        ifc1.in_valid = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        chk_idle1("n1_rst");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ks_serial_adder.md
# ks_serial_adder

Byte-serial multi-byte adder built around the 8-bit Kogge-Stone adder. It accepts one byte of each operand per beat, least-significant byte first, and chains the carry across beats. It emits one registered sum byte per beat, with flags on the last byte, and uses valid/ready handshakes on both sides. It sits between the pin-level operand bus (`ui_in`/`uio_in`) and the output/readback logic, extending the 8-bit datapath to NBYTES×8-bit addition.

## Interface
- `NBYTES`, default 4: operand length in bytes; legal range 1..16.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clr` in 1: synchronous abort of the current transaction.
- `in_valid` in 1: operand byte pair valid.
- `in_ready` out 1: block can accept a pair.
- `in_a` in 8: operand A byte.
- `in_b` in 8: operand B byte.
- `out_valid` out 1: sum byte valid.
- `out_ready` in 1: consumer accepts the sum byte.
- `out_sum` out 8: sum byte.
- `out_last` out 1: sum byte is the most-significant byte (index NBYTES-1).
- `out_cout` out 1: final carry out; meaningful only when `out_last` is 1, otherwise 0.
- `out_ovf` out 1: signed overflow of the full-width add; valid with `out_last`, otherwise 0.
- `out_zero` out 1: all NBYTES sum bytes are zero; valid with `out_last`, otherwise 0.

## Operation
- Input accept: `in_valid && in_ready`. Output accept: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is a single output register with pass-through ready; no skid buffer.
- Byte index counter `idx` runs 0..NBYTES-1 and wraps to 0 after the last accepted byte.
- On an input accept:
  - Compute `{c, s} = in_a + in_b + carry`.
  - Register `out_sum = s`.
  - Update `carry = c`, or clear it to 0 if the byte is the last one.
  - Accumulate `zacc &= (s == 0)`.
- Last byte (`idx == NBYTES-1`):
  - `out_last = 1`, `out_cout = c`.
  - `out_ovf = (a7 == b7) && (s7 != a7)`, using bit 7 of `in_a`, `in_b`, `s`.
  - `out_zero = zacc && (s == 0)`.
  - `zacc` reloads to 1 for the next transaction.
- States (in the shared package):
  - IDLE: `idx == 0`, carry 0.
  - RUN: mid-operand.
  - IDLE→RUN on accept of byte 0 when NBYTES > 1.
  - RUN→IDLE on accept of the last byte.
  - When NBYTES = 1, every beat is last and the FSM stays in IDLE.
- `clr`:
  - Returns to IDLE: `idx = 0`, carry = 0, `zacc = 1`, `out_valid = 0`.
  - Any input beat in the same cycle is dropped.
  - Any pending output byte is discarded.
- Output hold: while `out_valid && !out_ready`, all `out_*` signals stay stable.
- Arithmetic is unsigned modulo 2^(8·NBYTES). The overflow flag uses a two's-complement interpretation.

## Timing
- Reset values: `out_valid = 0`, `out_sum = 0`, `out_last = 0`, `out_cout = 0`, `out_ovf = 0`, `out_zero = 0`, `in_ready = 1`. Internally `idx = 0`, carry = 0, `zacc = 1`, state IDLE.
- Latency: one cycle from input accept to `out_valid`.
- Throughput: one byte per cycle when `out_ready` is held at 1.
- Reset or `clr` asserted mid-transaction takes effect at the next edge. Reset has priority over `clr`; `clr` has priority over a handshake.
- Simultaneous output accept and input accept: the new byte replaces the old one in the same edge, and `out_valid` stays 1.
- `in_ready` depends combinationally on `out_ready`.

## Structure
- Package `ks_pkg` holds:
  - the state enum (IDLE, RUN),
  - `KS_W = 8`,
  - `KS_MAX_BYTES = 16`,
  - the index width function `$clog2(NBYTES)`, with a minimum of 1.
- Sub-module `ks_adder8`: combinational 8-bit Kogge-Stone adder with carry-in and carry-out. Ports are `a[7:0]`, `b[7:0]`, `cin`, `sum[7:0]`, `cout`. It uses a log2(8) = 3-level prefix network and is instantiated once.
- Top level contains: FSM, index counter, carry register, zero accumulator, and output register.

## Test plan
- NBYTES=4, 0x000000FF + 0x00000001, `out_ready` = 1 → sum bytes 00,01,00,00 on consecutive cycles; last byte has `cout=0`, `ovf=0`, `zero=0`.
- 0xFFFFFFFF + 0x00000001 → bytes 00,00,00,00; last has `cout=1`, `ovf=0`, `zero=1`.
- 0x7FFFFFFF + 0x00000001 → bytes 00,00,00,80; last has `cout=0`, `ovf=1`, `zero=0`.
- Backpressure: `out_ready` = 0 for 3 cycles after byte 1 → `in_ready` = 0, `out_sum` held at the byte-1 value, no byte lost. The final result matches the no-stall run.
- `clr` after 2 bytes of 0xFFFFFFFF + 1, then a new 0x00000002 + 0x00000003 → the first beat emits 05 with no stale carry; the last byte has `cout=0`.
- Reset during RUN, and separately with NBYTES=1 and 0x80 + 0x80 → after reset all outputs are 0 and `in_ready` = 1. For NBYTES=1, each beat gives `out_last=1`, sum 00, `cout=1`, `ovf=1`, `zero=1`.
